// File: rtl/uart_bootloader.sv
// Target side of the host boot protocol: decodes 'W'rite / 'E'nd commands from the
// UART receiver, writes payload bytes to RAM over a 68k-style bus and replies with a checksum.
module uart_bootloader #(
  parameter int          ADDR_W    = 18,
  parameter logic [7:0]  CMD_WRITE = 8'h57,
  parameter logic [7:0]  CMD_END   = 8'h45,
  parameter logic [7:0]  NAK_BYTE  = 8'h3F,
  parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_avail,
  output logic              rx_avail_clear,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_active,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data_write,
  output logic              mem_uds,
  output logic              mem_lds,
  output logic              mem_rw,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              bootmode_active,
  output logic              bootmode_end_cmd,
  output logic [3:0]        o_dbg_state
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_A2    = 4'd1;
  localparam logic [3:0] S_A1    = 4'd2;
  localparam logic [3:0] S_A0    = 4'd3;
  localparam logic [3:0] S_L1    = 4'd4;
  localparam logic [3:0] S_L0    = 4'd5;
  localparam logic [3:0] S_DATA  = 4'd6;
  localparam logic [3:0] S_MEMWR = 4'd7;
  localparam logic [3:0] S_SUM   = 4'd8;
  localparam logic [3:0] S_NAK   = 4'd9;
  localparam logic [3:0] S_END   = 4'd10;
  localparam logic [3:0] S_DONE  = 4'd11;

  localparam logic [23:0] TMO_LAST = TIMEOUT - 24'd1;

  logic [3:0]      r_state;
  logic [7:0]      r_sum;
  logic [ADDR_W:0] r_baddr;
  logic [15:0]     r_len;
  logic [23:0]     r_tmo;
  logic            r_rx_clear;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic            r_mem_req;
  logic            r_mem_rw;
  logic            r_uds;
  logic            r_lds;
  logic [15:0]     r_wdata;
  logic            r_boot_active;
  logic            r_end_cmd;

  logic            w_timed;
  logic            w_rx_state;
  logic            w_consume;
  logic [15:0]     w_len_new;

  // Handshakes: an rx byte is taken when rx_avail=1 in a receiving state and no clear
  // pulse is already out; a bus cycle holds req and its qualifiers until mem_ack=1.
  assign w_timed    = (r_state >= S_A2) && (r_state <= S_DATA);
  assign w_rx_state = w_timed || (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_consume  = w_rx_state && rx_avail && !r_rx_clear;
  assign w_len_new  = {r_len[7:0], rx_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_sum         <= '0;
      r_baddr       <= '0;
      r_len         <= '0;
      r_tmo         <= '0;
      r_rx_clear    <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_mem_req     <= 1'b0;
      r_mem_rw      <= 1'b1;
      r_uds         <= 1'b0;
      r_lds         <= 1'b0;
      r_wdata       <= '0;
      r_boot_active <= 1'b1;
      r_end_cmd     <= 1'b0;
    end else begin
      r_rx_clear <= w_consume;
      r_tx_start <= 1'b0;
      r_end_cmd  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_consume) begin
          if (rx_data == CMD_WRITE) begin
            r_state <= S_A2;
            r_sum   <= '0;
          end else if (rx_data == CMD_END) begin
            r_state <= S_END;
          end else begin
            r_state <= S_NAK;
          end
        end
        // Shifting all three address bytes through drops bits above the byte address width.
        S_A2, S_A1, S_A0: if (w_consume) begin
          r_baddr <= {r_baddr[ADDR_W-8:0], rx_data};
          r_state <= r_state + 4'd1;
        end
        S_L1: if (w_consume) begin
          r_len   <= w_len_new;
          r_state <= S_L0;
        end
        S_L0: if (w_consume) begin
          r_len   <= w_len_new;
          r_state <= (w_len_new == 16'd0) ? S_SUM : S_DATA;
        end
        S_DATA: if (w_consume) begin
          r_sum     <= r_sum + rx_data;
          r_wdata   <= {rx_data, rx_data};
          r_mem_req <= 1'b1;
          r_mem_rw  <= 1'b0;
          r_uds     <= ~r_baddr[0];
          r_lds     <= r_baddr[0];
          r_state   <= S_MEMWR;
        end
        S_MEMWR: if (mem_ack) begin
          r_mem_req <= 1'b0;
          r_mem_rw  <= 1'b1;
          r_uds     <= 1'b0;
          r_lds     <= 1'b0;
          r_baddr   <= r_baddr + 1'b1;
          r_len     <= r_len - 16'd1;
          r_state   <= (r_len == 16'd1) ? S_SUM : S_DATA;
        end
        S_SUM: if (!tx_active) begin
          r_tx_start <= 1'b1;
          r_tx_data  <= r_sum;
          r_sum      <= '0;
          r_state    <= S_IDLE;
        end
        S_NAK: if (!tx_active) begin
          r_tx_start <= 1'b1;
          r_tx_data  <= NAK_BYTE;
          r_state    <= S_IDLE;
        end
        S_END: begin
          r_end_cmd     <= 1'b1;
          r_boot_active <= 1'b0;
          r_state       <= S_DONE;
        end
        S_DONE: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
      // Inter-byte watchdog; a consumed byte always wins over expiry in the same cycle.
      if (w_timed && !w_consume) begin
        if (r_tmo == TMO_LAST) begin
          r_tmo   <= '0;
          r_state <= S_IDLE;
        end else begin
          r_tmo <= r_tmo + 24'd1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign rx_avail_clear   = r_rx_clear;
  assign tx_data          = r_tx_data;
  assign tx_start         = r_tx_start;
  assign mem_addr         = r_baddr[ADDR_W:1];
  assign mem_data_write   = r_wdata;
  assign mem_uds          = r_uds;
  assign mem_lds          = r_lds;
  assign mem_rw           = r_mem_rw;
  assign mem_req          = r_mem_req;
  assign bootmode_active  = r_boot_active;
  assign bootmode_end_cmd = r_end_cmd;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_uart_bootloader.sv
// Bench for uart_bootloader: UART/RAM/TX models around the DUT, scoreboard queues for
// expected bus writes and reply bytes, one task per scenario.
module tb_uart_bootloader;

  localparam int          ADDR_W = 18;
  localparam int          MW     = ADDR_W + 18;
  localparam logic [23:0] TMO    = 24'd50;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_avail = 1'b0;
  logic              rx_avail_clear;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_active = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data_write;
  logic              mem_uds, mem_lds, mem_rw, mem_req;
  logic              mem_ack;
  logic              bootmode_active, bootmode_end_cmd;
  logic [3:0]        dbg_state;

  logic [MW-1:0] exp_mem_q[$];
  logic [7:0]    exp_tx_q[$];
  logic [7:0]    payload[16];
  int n_checks = 0;
  int n_pass = 0;
  int ack_delay = 0;
  int ack_count = 0;
  int write_count = 0;
  int end_pulses = 0;

  uart_bootloader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_avail_clear(rx_avail_clear),
    .tx_data(tx_data), .tx_start(tx_start), .tx_active(tx_active),
    .mem_addr(mem_addr), .mem_data_write(mem_data_write),
    .mem_uds(mem_uds), .mem_lds(mem_lds), .mem_rw(mem_rw),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .bootmode_active(bootmode_active), .bootmode_end_cmd(bootmode_end_cmd),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM responder / write scoreboard ----------------
  initial begin : mem_responder
    logic [MW-1:0] got;
    logic [MW-1:0] exp;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset_n && mem_req) begin
        write_count++;
        got = {mem_addr, mem_data_write, mem_uds, mem_lds};
        n_checks++;
        if (exp_mem_q.size() == 0)
          $display("FAIL mem_unexpected: got %h, required no write", got);
        else if (got !== exp_mem_q[0] || mem_rw !== 1'b0)
          $display("FAIL mem_start: got %h rw=%b, required %h rw=0", got, mem_rw, exp_mem_q[0]);
        else n_pass++;
        if (ack_delay > 0) begin
          repeat (ack_delay) @(posedge clk);
          #1;
        end
        if (mem_req) begin
          got = {mem_addr, mem_data_write, mem_uds, mem_lds};
          if (exp_mem_q.size() > 0) exp = exp_mem_q.pop_front();
          else exp = '1;
          n_checks++;
          if (got !== exp || mem_rw !== 1'b0)
            $display("FAIL mem_hold: got %h rw=%b, required %h rw=0", got, mem_rw, exp);
          else n_pass++;
          mem_ack = 1'b1;
          ack_count++;
          @(posedge clk); #1;
          mem_ack = 1'b0;
          n_checks++;
          if (mem_req !== 1'b0 || mem_rw !== 1'b1 || mem_uds !== 1'b0 || mem_lds !== 1'b0)
            $display("FAIL mem_release: got req=%b rw=%b uds=%b lds=%b, required 0 1 0 0",
                     mem_req, mem_rw, mem_uds, mem_lds);
          else n_pass++;
        end
      end
    end
  end

  // ---------------- TX / END monitor ----------------
  initial begin : tx_monitor
    logic prev_active;
    logic [7:0] e;
    prev_active = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n_checks++;
        if (exp_tx_q.size() == 0) begin
          $display("FAIL tx_unexpected: got %h, required no reply", tx_data);
        end else begin
          e = exp_tx_q.pop_front();
          if (tx_data !== e || prev_active !== 1'b0)
            $display("FAIL tx_reply: got %h (tx_active=%b), required %h with tx_active=0",
                     tx_data, prev_active, e);
          else n_pass++;
        end
      end
      if (bootmode_end_cmd) end_pulses++;
      prev_active = tx_active;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_avail = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rx_avail_clear && n < 200);
    rx_avail = 1'b0;
    if (!rx_avail_clear) begin
      n_checks++;
      $display("FAIL rx_consume: byte %h not consumed after %0d cycles, required consume", b, n);
    end
  endtask

  task automatic send_write(input logic [23:0] a, input logic [15:0] n);
    logic [ADDR_W:0] ba;
    logic [7:0] s;
    ba = a[ADDR_W:0];
    s  = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      exp_mem_q.push_back({ba[ADDR_W:1], payload[i], payload[i], ~ba[0], ba[0]});
      s  = s + payload[i];
      ba = ba + 1'b1;
    end
    exp_tx_q.push_back(s);
    send_byte(8'h57);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < int'(n); i++) send_byte(payload[i]);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rx_avail_clear, tx_start, tx_data, mem_req, mem_uds, mem_lds, bootmode_end_cmd} !== '0)
      $display("FAIL reset_zero: got clr=%b txs=%b txd=%h req=%b uds=%b lds=%b end=%b, required all 0",
               rx_avail_clear, tx_start, tx_data, mem_req, mem_uds, mem_lds, bootmode_end_cmd);
    else n_pass++;
    n_checks++;
    if (mem_addr !== '0 || mem_data_write !== 16'h0000)
      $display("FAIL reset_bus: got addr=%h data=%h, required 0 0", mem_addr, mem_data_write);
    else n_pass++;
    n_checks++;
    if (bootmode_active !== 1'b1 || mem_rw !== 1'b1)
      $display("FAIL reset_ones: got boot=%b rw=%b, required 1 1", bootmode_active, mem_rw);
    else n_pass++;
    reset_n = 1'b1;
    settle(3);
    n_checks++;
    if (bootmode_active !== 1'b1 || mem_req !== 1'b0 || tx_start !== 1'b0)
      $display("FAIL reset_idle: got boot=%b req=%b txs=%b, required 1 0 0",
               bootmode_active, mem_req, tx_start);
    else n_pass++;
  endtask

  task automatic test_two_writes;
    int w0;
    w0 = write_count;
    payload[0] = 8'hAA;
    payload[1] = 8'hBB;
    send_write(24'h000010, 16'd2);
    settle(30);
    n_checks++;
    if (write_count - w0 !== 2)
      $display("FAIL two_writes_count: got %0d, required 2", write_count - w0);
    else n_pass++;
    n_checks++;
    if (exp_mem_q.size() !== 0 || exp_tx_q.size() !== 0)
      $display("FAIL two_writes_drain: got mem=%0d tx=%0d left, required 0 0",
               exp_mem_q.size(), exp_tx_q.size());
    else n_pass++;
  endtask

  task automatic test_single_and_empty;
    int w0;
    payload[0] = 8'h5A;
    tx_active = 1'b1;
    send_write(24'h000003, 16'd1);
    settle(15);
    n_checks++;
    if (exp_tx_q.size() !== 1)
      $display("FAIL reply_wait: got %0d replies pending, required 1 while tx_active", exp_tx_q.size());
    else n_pass++;
    tx_active = 1'b0;
    settle(10);
    n_checks++;
    if (exp_mem_q.size() !== 0 || exp_tx_q.size() !== 0)
      $display("FAIL single_drain: got mem=%0d tx=%0d, required 0 0", exp_mem_q.size(), exp_tx_q.size());
    else n_pass++;
    w0 = write_count;
    send_write(24'h000000, 16'd0);
    settle(20);
    n_checks++;
    if (write_count !== w0 || exp_tx_q.size() !== 0)
      $display("FAIL empty_write: got writes=%0d tx left=%0d, required 0 0",
               write_count - w0, exp_tx_q.size());
    else n_pass++;
  endtask

  task automatic test_nak;
    int w0;
    w0 = write_count;
    exp_tx_q.push_back(8'h3F);
    send_byte(8'h41);
    settle(10);
    n_checks++;
    if (exp_tx_q.size() !== 0 || write_count !== w0)
      $display("FAIL nak: got tx left=%0d writes=%0d, required 0 0", exp_tx_q.size(), write_count - w0);
    else n_pass++;
    test_two_writes();
  endtask

  task automatic test_back_to_back_wrap;
    int a0, n;
    ack_delay = 5;
    payload[0] = 8'h11;
    payload[1] = 8'h22;
    exp_mem_q.push_back({18'h3FFFF, 16'h1111, 2'b01});
    exp_mem_q.push_back({18'h00000, 16'h2222, 2'b10});
    exp_tx_q.push_back(8'h33);
    send_byte(8'h57);
    send_byte(8'h07);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    a0 = ack_count;
    rx_data  = 8'h22;
    rx_avail = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rx_avail_clear && n < 100);
    rx_avail = 1'b0;
    n_checks++;
    if (!rx_avail_clear || ack_count - a0 !== 1)
      $display("FAIL pending_byte: got clr=%b acks_before=%0d, required clr=1 after 1 ack",
               rx_avail_clear, ack_count - a0);
    else n_pass++;
    settle(30);
    n_checks++;
    if (exp_mem_q.size() !== 0 || exp_tx_q.size() !== 0)
      $display("FAIL wrap_drain: got mem=%0d tx=%0d, required 0 0", exp_mem_q.size(), exp_tx_q.size());
    else n_pass++;
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_write;
    ack_delay = 20;
    exp_mem_q.push_back({18'h00008, 16'hAAAA, 2'b10});
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hAA);
    settle(3);
    n_checks++;
    if (mem_req !== 1'b1)
      $display("FAIL midwrite_req: got %b, required 1", mem_req);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || bootmode_active !== 1'b1 || mem_rw !== 1'b1)
      $display("FAIL async_reset: got req=%b boot=%b rw=%b, required 0 1 1",
               mem_req, bootmode_active, mem_rw);
    else n_pass++;
    exp_mem_q.delete();
    settle(2);
    reset_n = 1'b1;
    settle(30);
    ack_delay = 0;
    test_two_writes();
  endtask

  task automatic test_timeout_and_end;
    int e0, w0;
    send_byte(8'h57);
    send_byte(8'h00);
    settle(int'(TMO) + 10);
    exp_tx_q.push_back(8'h3F);
    send_byte(8'h41);
    settle(15);
    n_checks++;
    if (exp_tx_q.size() !== 0)
      $display("FAIL timeout_idle: got %0d replies missing, required 0", exp_tx_q.size());
    else n_pass++;
    e0 = end_pulses;
    send_byte(8'h45);
    settle(10);
    n_checks++;
    if (end_pulses - e0 !== 1 || bootmode_active !== 1'b0)
      $display("FAIL end_cmd: got pulses=%0d boot=%b, required 1 0", end_pulses - e0, bootmode_active);
    else n_pass++;
    w0 = write_count;
    send_byte(8'h57);
    send_byte(8'h00);
    settle(20);
    n_checks++;
    if (write_count !== w0 || exp_tx_q.size() !== 0 || bootmode_active !== 1'b0)
      $display("FAIL done_discard: got writes=%0d boot=%b, required 0 0", write_count - w0, bootmode_active);
    else n_pass++;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_two_writes();
    test_single_and_empty();
    test_nak();
    test_back_to_back_wrap();
    test_reset_mid_write();
    test_timeout_and_end();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
